// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT memory sequencer and its address generator.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    UNLOAD
  } fft_state_e;

  localparam int FFT_LOG2N_DEF = 12;

  // Width of the stage index. Never narrower than one bit.
  function automatic int fft_stage_w(input int log2n);
    return (log2n < 2) ? 1 : $clog2(log2n);
  endfunction

  localparam int FFT_STAGE_W_DEF = fft_stage_w(FFT_LOG2N_DEF);

  // Reverses the low 'width' bits of v. Bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] src;
    logic [31:0] r;
    src = v;
    r   = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r   = {r[30:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational radix-2 in-place butterfly addressing. It maps (stage, pair index)
// to the operand addresses a and b and to the twiddle index.
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N   = FFT_LOG2N_DEF,
  parameter int STAGE_W = fft_stage_w(LOG2N)
) (
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [LOG2N-2:0]   k_i,
  output logic [LOG2N-1:0]   a_o,
  output logic [LOG2N-1:0]   b_o,
  output logic [LOG2N-2:0]   tw_o
);

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] idx;
  logic [LOG2N-1:0] a;

  always_comb begin
    k_ext = {1'b0, k_i};
    span  = LOG2N'(1) << stage_i;
    idx   = k_ext & (span - 1'b1);
    // Open a zero at bit 'stage' in k. The widened shift keeps the top stage from overflowing.
    a     = ((k_ext >> stage_i) << ({1'b0, stage_i} + 1'b1)) | idx;
    a_o   = a;
    b_o   = a + span;
    tw_o  = idx[LOG2N-2:0] << (STAGE_W'(LOG2N - 1) - stage_i);
  end

endmodule

// File: rtl/fft_mem_sequencer.sv
// FFT working-memory sequencer. It loads samples at bit-reversed addresses, walks the
// in-place radix-2 stages with a delayed write-back, and unloads results in natural order.
module fft_mem_sequencer
  import fft_pkg::*;
#(
  parameter  int LOG2N   = FFT_LOG2N_DEF,
  parameter  int DATA_W  = 16,
  parameter  int BF_LAT  = 4,
  localparam int STAGE_W = fft_stage_w(LOG2N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  output logic               mem_write,
  output logic [LOG2N-1:0]   mem_write_adr,
  output logic [DATA_W-1:0]  mem_data_in,
  output logic [LOG2N-1:0]   mem_read_adr,
  input  logic [DATA_W-1:0]  bf_result,
  output logic               bf_sel,
  output logic [LOG2N-2:0]   bf_twiddle,
  output logic [STAGE_W-1:0] stage,
  output logic               out_valid,
  output logic [LOG2N-1:0]   out_index,
  output logic               busy,
  output logic               done
);

  localparam logic [LOG2N-1:0]   CNT_LAST   = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [3:0]         DRN_LAST   = 4'(BF_LAT - 1);

  fft_state_e         state_q, state_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [3:0]         drn_q, drn_d;
  logic               ul_end_q, ul_end_d;
  logic [LOG2N-1:0]   rd_adr_q, rd_adr_d;
  logic               out_vld_q, out_vld_d;
  logic [LOG2N-1:0]   out_idx_q, out_idx_d;

  logic [BF_LAT-1:0]             wb_vld_q;
  logic [BF_LAT-1:0][LOG2N-1:0]  wb_adr_q;

  logic             ld_write;
  logic             wb_write;
  logic [LOG2N-1:0] ld_adr;
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [LOG2N-2:0] gen_tw;

  // cnt_q doubles as the read-cycle counter in COMPUTE: pair index k in the upper bits, operand select in bit 0.
  fft_bf_addr_gen #(
    .LOG2N   (LOG2N),
    .STAGE_W (STAGE_W)
  ) u_addr_gen (
    .stage_i (stage_q),
    .k_i     (cnt_q[LOG2N-1:1]),
    .a_o     (gen_a),
    .b_o     (gen_b),
    .tw_o    (gen_tw)
  );

  assign ld_adr = LOG2N'(bitrev(32'(cnt_q), LOG2N));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    drn_d      = drn_q;
    ul_end_d   = ul_end_q;
    rd_adr_d   = rd_adr_q;
    out_vld_d  = 1'b0;
    out_idx_d  = '0;
    s_ready    = 1'b0;
    ld_write   = 1'b0;
    bf_sel     = 1'b0;
    bf_twiddle = '0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ld_write = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        rd_adr_d   = cnt_q[0] ? gen_b : gen_a;
        bf_sel     = cnt_q[0];
        bf_twiddle = gen_tw;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end
      end
      DRAIN: begin
        // BF_LAT idle cycles let the final write of a stage land before the next stage reads.
        drn_d = drn_q + 1'b1;
        if (drn_q == DRN_LAST) begin
          drn_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d  = UNLOAD;
            ul_end_d = 1'b0;
          end else begin
            state_d = COMPUTE;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      UNLOAD: begin
        if (ul_end_q) begin
          done     = 1'b1;
          state_d  = IDLE;
          ul_end_d = 1'b0;
        end else begin
          rd_adr_d  = cnt_q;
          out_vld_d = 1'b1;
          out_idx_d = cnt_q;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) ul_end_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_write = wb_vld_q[BF_LAT-1] && (state_q == COMPUTE || state_q == DRAIN);

  always_comb begin
    mem_write     = ld_write | wb_write;
    mem_write_adr = '0;
    mem_data_in   = '0;
    if (ld_write) begin
      mem_write_adr = ld_adr;
      mem_data_in   = s_data;
    end else if (wb_write) begin
      mem_write_adr = wb_adr_q[BF_LAT-1];
      mem_data_in   = bf_result;
    end
  end

  assign mem_read_adr = rd_adr_d;
  assign stage        = stage_q;
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_vld_q;
  assign out_index    = out_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stage_q   <= '0;
      drn_q     <= '0;
      ul_end_q  <= 1'b0;
      rd_adr_q  <= '0;
      out_vld_q <= 1'b0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      drn_q     <= drn_d;
      ul_end_q  <= ul_end_d;
      rd_adr_q  <= rd_adr_d;
      out_vld_q <= out_vld_d;
      out_idx_q <= out_idx_d;
    end
  end

  // Write-back delay line: a valid flag per slot, plus the address riding alongside it.
  always_ff @(posedge clk) begin
    if (rst) wb_vld_q <= '0;
    else     wb_vld_q <= {wb_vld_q[BF_LAT-2:0], state_q == COMPUTE};
  end

  always_ff @(posedge clk) begin
    wb_adr_q <= {wb_adr_q[BF_LAT-2:0], rd_adr_d};
  end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed bench: an N=8 instance for address/write-back/unload detail, and a default N=4096 instance for full-run timing.
module tb_fft_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance: LOG2N=3, BF_LAT=4
  logic        start3, s_valid3, s_ready3, mem_write3, bf_sel3, out_valid3, busy3, done3;
  logic [15:0] s_data3, mem_data_in3, bf_result3;
  logic [2:0]  mem_write_adr3, mem_read_adr3, out_index3;
  logic [1:0]  bf_twiddle3, stage3;

  // Default instance: LOG2N=12, BF_LAT=4
  logic        start12, s_valid12, s_ready12, mem_write12, bf_sel12, out_valid12, busy12, done12;
  logic [15:0] s_data12, mem_data_in12;
  logic [11:0] mem_write_adr12, mem_read_adr12, out_index12;
  logic [10:0] bf_twiddle12;
  logic [3:0]  stage12;

  fft_mem_sequencer #(.LOG2N(3), .DATA_W(16), .BF_LAT(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .s_valid(s_valid3), .s_ready(s_ready3),
    .s_data(s_data3), .mem_write(mem_write3), .mem_write_adr(mem_write_adr3),
    .mem_data_in(mem_data_in3), .mem_read_adr(mem_read_adr3), .bf_result(bf_result3),
    .bf_sel(bf_sel3), .bf_twiddle(bf_twiddle3), .stage(stage3), .out_valid(out_valid3),
    .out_index(out_index3), .busy(busy3), .done(done3)
  );

  fft_mem_sequencer u_dut12 (
    .clk(clk), .rst(rst), .start(start12), .s_valid(s_valid12), .s_ready(s_ready12),
    .s_data(s_data12), .mem_write(mem_write12), .mem_write_adr(mem_write_adr12),
    .mem_data_in(mem_data_in12), .mem_read_adr(mem_read_adr12), .bf_result(16'd0),
    .bf_sel(bf_sel12), .bf_twiddle(bf_twiddle12), .stage(stage12), .out_valid(out_valid12),
    .out_index(out_index12), .busy(busy12), .done(done12)
  );

  // Butterfly stand-in: read address + 100, returned 4 cycles later
  logic [2:0] bf_pipe [4];
  always @(posedge clk) begin
    bf_pipe[0] <= mem_read_adr3;
    bf_pipe[1] <= bf_pipe[0];
    bf_pipe[2] <= bf_pipe[1];
    bf_pipe[3] <= bf_pipe[2];
  end
  assign bf_result3 = 16'(bf_pipe[3]) + 16'd100;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  int vpat [10]      = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int ld_adr_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int rd_tab [3][8]  = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                         '{0, 2, 1, 3, 4, 6, 5, 7},
                         '{0, 4, 1, 5, 2, 6, 3, 7}};
  int tw_tab [3][8]  = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                         '{0, 0, 2, 2, 0, 0, 2, 2},
                         '{0, 0, 1, 1, 2, 2, 3, 3}};

  int  nacc;
  int  busy_cnt, wr_cnt, ov_cnt, done_cnt;
  logic fin;

  initial begin
    rst = 1'b1;
    start3 = 1'b0; s_valid3 = 1'b0; s_data3 = '0;
    start12 = 1'b0; s_valid12 = 1'b0; s_data12 = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_eq("rst_busy", busy3, 1'b0);
    chk_eq("rst_we", mem_write3, 1'b0);
    chk_eq("rst_ready", s_ready3, 1'b0);
    chk_eq("rst_rdadr", mem_read_adr3, 0);
    chk_eq("rst_stage", stage3, 0);
    chk_eq("rst_ovld", out_valid3, 1'b0);
    chk_eq("rst_done", done3, 1'b0);

    // LOAD: 10..17 with a two-cycle gap after the third sample
    @(posedge clk); #1;
    rst = 1'b0; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    nacc = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid3 = (vpat[c] != 0);
      s_data3  = 16'(10 + nacc);
      @(negedge clk);
      chk_eq("ld_ready", s_ready3, 1'b1);
      if (vpat[c] != 0) begin
        chk_eq("ld_we", mem_write3, 1'b1);
        chk_eq("ld_adr", mem_write_adr3, ld_adr_tab[nacc]);
        chk_eq("ld_data", mem_data_in3, 10 + nacc);
        nacc++;
      end else begin
        chk_eq("ld_gap_we", mem_write3, 1'b0);
      end
      @(posedge clk); #1;
    end
    s_valid3 = 1'b0;

    // COMPUTE/DRAIN: 12 cycles per stage, write-back 4 cycles after each read
    for (int c = 0; c < 36; c++) begin
      int s, r;
      s = c / 12;
      r = c % 12;
      @(negedge clk);
      chk_eq("cp_busy", busy3, 1'b1);
      chk_eq("cp_stage", stage3, s);
      chk_eq("cp_ready", s_ready3, 1'b0);
      if (r < 8) begin
        chk_eq("cp_rdadr", mem_read_adr3, rd_tab[s][r]);
        chk_eq("cp_bfsel", bf_sel3, r % 2);
        chk_eq("cp_tw", bf_twiddle3, tw_tab[s][r]);
      end else begin
        chk_eq("drn_hold", mem_read_adr3, 7);
      end
      if (r >= 4) begin
        chk_eq("wb_we", mem_write3, 1'b1);
        chk_eq("wb_adr", mem_write_adr3, rd_tab[s][r-4]);
        chk_eq("wb_data", mem_data_in3, rd_tab[s][r-4] + 100);
      end else begin
        chk_eq("wb_idle", mem_write3, 1'b0);
      end
      @(posedge clk); #1;
    end

    // UNLOAD: addresses 0..7, outputs one cycle behind, done with index 7
    for (int u = 0; u < 9; u++) begin
      @(negedge clk);
      chk_eq("ul_busy", busy3, 1'b1);
      chk_eq("ul_we", mem_write3, 1'b0);
      if (u < 8) chk_eq("ul_rdadr", mem_read_adr3, u);
      chk_eq("ul_ovld", out_valid3, u >= 1);
      if (u >= 1) chk_eq("ul_idx", out_index3, u - 1);
      chk_eq("ul_done", done3, u == 8);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_eq("end_busy", busy3, 1'b0);
    chk_eq("end_done", done3, 1'b0);
    chk_eq("end_ovld", out_valid3, 1'b0);

    // Reset in the middle of stage 1
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; s_valid3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data3 = 16'(20 + i);
      @(posedge clk); #1;
    end
    s_valid3 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_eq("pre_rst_stage", stage3, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("mrst_busy", busy3, 1'b0);
    chk_eq("mrst_we", mem_write3, 1'b0);
    chk_eq("mrst_ready", s_ready3, 1'b0);
    chk_eq("mrst_stage", stage3, 0);
    chk_eq("mrst_rdadr", mem_read_adr3, 0);
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0; s_valid3 = 1'b1; s_data3 = 16'd55;
    @(negedge clk);
    chk_eq("rl_ready", s_ready3, 1'b1);
    chk_eq("rl_we", mem_write3, 1'b1);
    chk_eq("rl_adr0", mem_write_adr3, 0);
    chk_eq("rl_data0", mem_data_in3, 55);
    @(posedge clk); #1;
    s_data3 = 16'd56;
    @(negedge clk);
    chk_eq("rl_adr1", mem_write_adr3, 4);
    chk_eq("rl_data1", mem_data_in3, 56);
    @(posedge clk); #1;
    s_valid3 = 1'b0;

    // Default-size full run, with start pulses while busy
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start12 = 1'b1; s_valid12 = 1'b1;
    @(posedge clk); #1;
    start12 = 1'b0;
    busy_cnt = 0; wr_cnt = 0; ov_cnt = 0; done_cnt = 0; fin = 1'b0;
    for (int c = 0; c < 70000 && !fin; c++) begin
      @(negedge clk);
      if (busy12) begin
        busy_cnt++;
        if (mem_write12) wr_cnt++;
        if (out_valid12) ov_cnt++;
        if (done12) done_cnt++;
      end else begin
        fin = 1'b1;
      end
      @(posedge clk); #1;
      start12  = (busy_cnt == 10 || busy_cnt == 30000 || busy_cnt == 57000);
      s_data12 = 16'(busy_cnt);
    end
    start12 = 1'b0;
    chk_eq("big_finished", fin, 1'b1);
    chk_eq("big_busy_cycles", busy_cnt, 4096 + 12 * (4096 + 4) + 4097);
    chk_eq("big_writes", wr_cnt, 4096 + 12 * 4096);
    chk_eq("big_outputs", ov_cnt, 4096);
    chk_eq("big_done", done_cnt, 1);
    @(negedge clk);
    chk_eq("big_idle_after", busy12, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
